// File: rtl/ysyx_22050243_ifu_pkg.sv
// Shared types and constants for the ysyx_22050243 instruction fetch unit.
package ysyx_22050243_ifu_pkg;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/ysyx_22050243_ifu_fifo.sv
// Small synchronous FIFO of {pc, inst} entries; head is read from registered storage.
module ysyx_22050243_ifu_fifo
    import ysyx_22050243_ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_reg [DEPTH];
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW-1:0]  wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           do_pop;
    logic           do_push;

    assign do_pop  = pop && (count_reg != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count_reg < CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/ysyx_22050243_ifu.sv
// Instruction fetch unit: one outstanding imem request, {pc, inst} output buffer, redirect flush.
// Optional performance counters are enabled with YSYX_22050243_IFU_PERF_EN.
module ysyx_22050243_ifu
    import ysyx_22050243_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst
`ifdef YSYX_22050243_IFU_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_drop_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_t    state_reg, state_next;
    logic [63:0]   fetch_pc_reg, fetch_pc_next;
    logic [63:0]   req_pc_reg, req_pc_next;
    logic [CW-1:0] fifo_count;
    logic          req_hs;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    assign req_hs     = imem_req_valid && imem_req_ready;
    assign pop        = id_valid && id_ready;
    assign push_entry = '{pc: req_pc_reg, inst: imem_rsp_data};

    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        req_pc_next    = req_pc_reg;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        case (state_reg)
            REQ: begin
                imem_req_valid = !rst && (fifo_count < CW'(FIFO_DEPTH));
                if (redirect_valid) begin
                    // An accepted wrong-path request still owes us a response to discard.
                    state_next = req_hs ? DROP : REQ;
                end else if (req_hs) begin
                    req_pc_next   = fetch_pc_reg;
                    fetch_pc_next = fetch_pc_reg + 64'd4;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push       = !redirect_valid;
                    state_next = REQ;
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
        if (redirect_valid) begin
            fetch_pc_next = align_word(redirect_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= REQ;
            fetch_pc_reg <= align_word(RESET_PC);
            req_pc_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
        end
    end

    ysyx_22050243_ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .dout  (head_entry),
        .count (fifo_count)
    );

    assign imem_req_addr = fetch_pc_reg;
    assign id_valid      = (fifo_count != '0);
    assign id_pc         = head_entry.pc;
    assign id_inst       = head_entry.inst;

`ifdef YSYX_22050243_IFU_PERF_EN
    logic [63:0]   perf_fetch_reg;
    logic [63:0]   perf_drop_reg;
    logic          rsp_drop;
    logic [CW-1:0] flushed;

    assign rsp_drop = imem_rsp_valid && ((state_reg == DROP) || ((state_reg == WAIT) && redirect_valid));
    // The entry popped in a redirect cycle was consumed, so it is not counted as dropped.
    assign flushed  = redirect_valid ? (fifo_count - CW'(pop)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_reg <= '0;
            perf_drop_reg  <= '0;
        end else begin
            perf_fetch_reg <= perf_fetch_reg + 64'(push);
            perf_drop_reg  <= perf_drop_reg + 64'(rsp_drop) + 64'(flushed);
        end
    end

    assign perf_fetch_cnt = perf_fetch_reg;
    assign perf_drop_cnt  = perf_drop_reg;
`endif

endmodule

// File: tb/tb_ysyx_22050243_ifu.sv
// Directed testbench for ysyx_22050243_ifu with a behavioural in-order imem model.
module tb_ysyx_22050243_ifu;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
`ifdef YSYX_22050243_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_drop_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_22050243_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
`ifdef YSYX_22050243_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_cnt = 0;
    int          reqv_cnt = 0;
    logic [63:0] req_q[$];
    logic [95:0] pop_q[$];
    int          pop_cyc_q[$];
    bit          const_data = 1'b1;
    int          rsp_delay = 1;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [63:0] pend_addr = '0;
    exp_t        tbl[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return const_data ? 32'h0000_0013 : (a[31:0] ^ 32'h5A5A_0013);
    endfunction

    function automatic logic [95:0] pop_at(input int i);
        return (i < pop_q.size()) ? pop_q[i] : 96'bx;
    endfunction

    function automatic logic [63:0] req_at(input int i);
        return (i < req_q.size()) ? req_q[i] : 64'bx;
    endfunction

    // Monitor and request acceptance, sampled mid-cycle.
    always begin
        @(negedge clk);
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (imem_req_valid) reqv_cnt++;
            if (imem_req_valid && imem_req_ready) begin
                req_q.push_back(imem_req_addr);
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                pend_cnt  = rsp_delay;
            end
            if (id_valid && id_ready) begin
                pop_q.push_back({id_pc, id_inst});
                pop_cyc_q.push_back(cyc_cnt);
            end
        end
    end

    // In-order imem response generation, rsp_delay cycles after acceptance.
    always begin
        @(posedge clk);
        cyc_cnt++;
        #1;
        imem_rsp_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(pend_addr);
                pend           = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        cyc();
        cyc();
        req_q.delete();
        pop_q.delete();
        pop_cyc_q.delete();
        reqv_cnt = 0;
        rst      = 1'b0;
        cyc_cnt  = 0;
    endtask

    task automatic wait_hs(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got no request handshake, expected one within 50 cycles", name);
        end
    endtask

    task automatic check_pops(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            logic [95:0] e;
            e = pop_at(i);
            check($sformatf("%s pop%0d pc", name, i), e[95:32], tbl[i].pc);
            check($sformatf("%s pop%0d inst", name, i), {32'd0, e[31:0]}, {32'd0, tbl[i].inst});
        end
    endtask

    initial begin
        bit found;

        // Reset values
        cyc();
        @(negedge clk);
        check("rst imem_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("rst id_valid", {63'd0, id_valid}, 64'd0);
        check("rst id_pc", id_pc, 64'd0);
        check("rst id_inst", {32'd0, id_inst}, 64'd0);

        // Zero-wait streaming, constant NOP data
        const_data = 1'b1;
        rsp_delay  = 1;
        tbl = '{'{64'h8000_0000, 32'h13}, '{64'h8000_0004, 32'h13}, '{64'h8000_0008, 32'h13}};
        do_reset();
        id_ready = 1'b1;
        repeat (10) cyc();
        check("t1 first pop cycle", 64'(pop_cyc_q.size() > 0 ? pop_cyc_q[0] : -1), 64'd2);
        check_pops("t1");
        check("t1 gap01", 64'(pop_cyc_q.size() > 2 ? pop_cyc_q[1] - pop_cyc_q[0] : -1), 64'd2);
        check("t1 gap12", 64'(pop_cyc_q.size() > 2 ? pop_cyc_q[2] - pop_cyc_q[1] : -1), 64'd2);

        // Back-pressure: buffer fills, requests stop, then drains in order
        const_data = 1'b0;
        tbl.delete();
        for (int i = 0; i < 4; i++) begin
            tbl.push_back('{64'h8000_0000 + 64'(4 * i), inst_of(64'h8000_0000 + 64'(4 * i))});
        end
        do_reset();
        repeat (20) cyc();
        check("t2 requests while stalled", 64'(req_q.size()), 64'd2);
        check("t2 req_valid cycles", 64'(reqv_cnt), 64'd2);
        check("t2 id_valid held", {63'd0, id_valid}, 64'd1);
        check("t2 req_valid when full", {63'd0, imem_req_valid}, 64'd0);
        id_ready = 1'b1;
        repeat (12) cyc();
        check_pops("t2");

        // Redirect while waiting for a slow response
        rsp_delay = 3;
        do_reset();
        id_ready = 1'b1;
        wait_hs("t3 first request");
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1003;
        cyc();
        redirect_valid = 1'b0;
        repeat (15) cyc();
        check("t3 req after redirect", req_at(1), 64'h8000_1000);
        tbl = '{'{64'h8000_1000, inst_of(64'h8000_1000)}};
        check_pops("t3");

        // Redirect coinciding with a response
        rsp_delay = 2;
        do_reset();
        id_ready = 1'b1;
        wait_hs("t4 first request");
        cyc();
        cyc();
        check("t4 rsp in redirect cycle", {63'd0, imem_rsp_valid}, 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        cyc();
        redirect_valid = 1'b0;
        check("t4 id_valid after drop", {63'd0, id_valid}, 64'd0);
        check("t4 req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("t4 req_addr", imem_req_addr, 64'h8000_2000);
        repeat (10) cyc();
        tbl = '{'{64'h8000_2000, inst_of(64'h8000_2000)}};
        check_pops("t4");

        // Redirect coinciding with the handshake of 0x80000010
        rsp_delay = 1;
        do_reset();
        id_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && imem_req_addr == 64'h8000_0010) begin
                redirect_valid = 1'b1;
                redirect_pc    = 64'h8000_3000;
                found = 1'b1;
                break;
            end
        end
        check("t5 reached 0x10 request", {63'd0, found}, 64'd1);
        cyc();
        redirect_valid = 1'b0;
        repeat (12) cyc();
        check("t5 req after 0x10", req_at(5), 64'h8000_3000);
        tbl.delete();
        for (int i = 0; i < 4; i++) begin
            tbl.push_back('{64'h8000_0000 + 64'(4 * i), inst_of(64'h8000_0000 + 64'(4 * i))});
        end
        tbl.push_back('{64'h8000_3000, inst_of(64'h8000_3000)});
        check_pops("t5");

`ifdef YSYX_22050243_IFU_PERF_EN
        // Performance counters
        rsp_delay = 1;
        do_reset();
        repeat (10) cyc();
        check("perf fetch after fill", perf_fetch_cnt, 64'd2);
        for (int k = 0; k < 3; k++) begin
            id_ready = 1'b1;
            cyc();
            id_ready = 1'b0;
            repeat (8) cyc();
        end
        check("perf fetch after 5", perf_fetch_cnt, 64'd5);
        check("perf drop before redirect", perf_drop_cnt, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_4000;
        cyc();
        redirect_valid = 1'b0;
        check("perf drop full flush", perf_drop_cnt, 64'd2);
        repeat (10) cyc();
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        wait_hs("perf refetch");
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_5000;
        cyc();
        redirect_valid = 1'b0;
        check("perf fetch final", perf_fetch_cnt, 64'd7);
        check("perf drop final", perf_drop_cnt, 64'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
